// File: rtl/layernorm_out_packer.sv
// Packs the LayerNorm 8-bit output stream into little-endian 64-bit words,
// tracking channel/token position and checking upstream frame alignment.
module layernorm_out_packer #(
    parameter int unsigned LANES = 8,
    parameter int unsigned CH_W  = 10,
    parameter int unsigned TOK_W = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CH_W-1:0]      channel_nums,
    input  logic [TOK_W-1:0]     token_nums,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [7:0]           s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [LANES*8-1:0]   m_data,
    output logic                 m_tok_last,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err_cfg,
    output logic                 err_align
);
    localparam int unsigned W  = LANES * 8;
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LANE_MAX = LW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_n;

    logic [CH_W-1:0]  cfg_ch, ch;
    logic [TOK_W-1:0] cfg_tok, tok;
    logic [LW-1:0]    lane;
    logic [W-9:0]     pack;
    logic             cfg_ok, accept, word_done, ch_end, tok_end, final_byte, out_take;

    assign cfg_ok     = (channel_nums[2:0] == 3'd0) && (channel_nums != '0) && (token_nums != '0);
    assign s_ready    = (state == RUN) && !(lane == LANE_MAX && m_valid && !m_ready);
    assign accept     = s_valid && s_ready;
    assign ch_end     = (ch == cfg_ch - CH_W'(1));
    assign tok_end    = (tok == cfg_tok - TOK_W'(1));
    // channel count is a multiple of 8, so the last channel always lands on lane 7
    assign final_byte = ch_end && tok_end;
    assign word_done  = accept && (lane == LANE_MAX);
    assign out_take   = m_valid && m_ready;
    assign busy       = (state != IDLE);

    always_comb begin
        state_n = state;
        if (start) begin
            state_n = cfg_ok ? RUN : IDLE;
        end else begin
            unique case (state)
                IDLE:    state_n = IDLE;
                RUN:     if (accept && final_byte) state_n = FLUSH;
                FLUSH:   if (out_take) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cfg_ch     <= '0;
            cfg_tok    <= '0;
            lane       <= '0;
            ch         <= '0;
            tok        <= '0;
            pack       <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_tok_last <= 1'b0;
            m_last     <= 1'b0;
            done       <= 1'b0;
            err_cfg    <= 1'b0;
            err_align  <= 1'b0;
        end else begin
            state <= state_n;
            done  <= (state == FLUSH) && out_take && !start;
            if (start) begin
                cfg_ch     <= channel_nums;
                cfg_tok    <= token_nums;
                lane       <= '0;
                ch         <= '0;
                tok        <= '0;
                pack       <= '0;
                m_valid    <= 1'b0;
                m_tok_last <= 1'b0;
                m_last     <= 1'b0;
                err_cfg    <= !cfg_ok;
                err_align  <= 1'b0;
            end else begin
                if (accept) begin
                    lane <= (lane == LANE_MAX) ? '0 : lane + LW'(1);
                    for (int unsigned i = 0; i < LANES - 1; i++) begin
                        if (lane == LW'(i)) pack[i*8 +: 8] <= s_data;
                    end
                    if (ch_end) begin
                        ch  <= '0;
                        tok <= tok + TOK_W'(1);
                    end else begin
                        ch  <= ch + CH_W'(1);
                    end
                    if (final_byte != s_last) err_align <= 1'b1;
                end
                if (word_done) begin
                    m_valid    <= 1'b1;
                    m_data     <= {s_data, pack};
                    m_tok_last <= ch_end;
                    m_last     <= final_byte;
                end else if (out_take) begin
                    m_valid    <= 1'b0;
                    m_tok_last <= 1'b0;
                    m_last     <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_layernorm_out_packer.sv
// Randomized bench for layernorm_out_packer: expected words are built directly
// from the byte stream of each frame and checked on every output handshake.
module tb_layernorm_out_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, s_valid, s_last, m_ready;
    logic [9:0]  channel_nums;
    logic [19:0] token_nums;
    logic [7:0]  s_data;
    logic        s_ready, m_valid, m_tok_last, m_last, busy, done, err_cfg, err_align;
    logic [63:0] m_data;

    layernorm_out_packer #(.LANES(8), .CH_W(10), .TOK_W(20)) dut (
        .clk(clk), .rst(rst), .start(start),
        .channel_nums(channel_nums), .token_nums(token_nums),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_tok_last(m_tok_last), .m_last(m_last),
        .busy(busy), .done(done), .err_cfg(err_cfg), .err_align(err_align)
    );

    typedef struct {
        logic [63:0] data;
        logic        tl;
        logic        last;
    } word_t;

    int          total = 0, bad = 0;
    word_t       exp_q[$];
    word_t       w;
    logic [7:0]  fb[];
    int unsigned acc_cnt = 0, nbytes = 0;
    bit          armed = 0, final_taken = 0, done_exp = 0, prev_stall = 0;
    logic [63:0] prev_data, first_word, last_word;
    logic        prev_tl, prev_last;
    int unsigned words_seen, tl_seen, last_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output monitor: samples mid-cycle, ahead of the edge that completes any handshake.
    always @(negedge clk) begin
        if (!rst) begin
            chk("s_ready", s_ready,
                armed && acc_cnt < nbytes && !(acc_cnt % 8 == 7 && m_valid && !m_ready));
            chk("busy", busy, armed && !final_taken);
            chk("done", done, done_exp);
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data, prev_data);
                chk("hold_tok_last", m_tok_last, prev_tl);
                chk("hold_last", m_last, prev_last);
            end
            done_exp = 0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h expected none", m_data);
                end else begin
                    w = exp_q.pop_front();
                    chk("word_data", m_data, w.data);
                    chk("word_tok_last", m_tok_last, w.tl);
                    chk("word_last", m_last, w.last);
                    if (words_seen == 0) first_word = m_data;
                    last_word = m_data;
                    words_seen++;
                    tl_seen   += int'(m_tok_last);
                    last_seen += int'(m_last);
                    if (w.last) begin
                        final_taken = 1;
                        done_exp    = 1;
                    end
                end
            end
            if (s_valid && s_ready) acc_cnt++;
            prev_stall = m_valid && !m_ready && !start;
            prev_data  = m_data;
            prev_tl    = m_tok_last;
            prev_last  = m_last;
        end
    end

    // mode: 0 ready always, 1 ready 1-of-3, 2 ready random 75%, 3 ready never
    task automatic run_frame(input int unsigned c, input int unsigned t, input int mode,
                             input int mis, input int unsigned stop_at, input bit seq);
        int unsigned n, cyc, budget;
        word_t       nq[$];
        word_t       nw;
        n = c * t;
        fb = new[n];
        for (int unsigned i = 0; i < n; i++) fb[i] = seq ? i[7:0] : 8'($urandom);
        for (int unsigned j = 0; j < n / 8; j++) begin
            nw.data = '0;
            for (int unsigned b = 0; b < 8; b++) nw.data[b*8 +: 8] = fb[8*j + b];
            nw.tl   = ((8*j + 8) % c) == 0;
            nw.last = (j == n / 8 - 1);
            nq.push_back(nw);
        end
        s_valid = 0;
        s_last  = 0;
        channel_nums = c[9:0];
        token_nums   = t[19:0];
        start = 1;
        @(posedge clk); #1;
        start = 0;
        armed = 1; acc_cnt = 0; nbytes = n; final_taken = 0; done_exp = 0; prev_stall = 0;
        exp_q = nq;
        words_seen = 0; tl_seen = 0; last_seen = 0;
        chk("start_drops_word", m_valid, 1'b0);
        chk("start_clears_align", err_align, 1'b0);
        chk("start_clears_cfg", err_cfg, 1'b0);
        cyc = 0;
        budget = n * 6 + 100;
        while (!(final_taken && !done_exp && exp_q.size() == 0) && cyc < budget &&
               !(stop_at != 0 && acc_cnt >= stop_at)) begin
            if (acc_cnt < n) begin
                s_valid = ($urandom_range(0, 9) < 8);
                s_data  = fb[acc_cnt];
                s_last  = (acc_cnt == n - 1) != (int'(acc_cnt) == mis);
            end else begin
                s_valid = 0;
                s_last  = 0;
                s_data  = 8'($urandom);
            end
            case (mode)
                0:       m_ready = 1;
                1:       m_ready = (cyc % 3 == 0);
                2:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = 0;
            endcase
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 0;
        s_last  = 0;
        if (cyc >= budget) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d cycles expected under %0d", cyc, budget);
        end
        if (stop_at == 0) begin
            m_ready = 1;
            chk("word_count", words_seen, n / 8);
            chk("tok_last_count", tl_seen, t);
            chk("last_count", last_seen, 1);
            chk("leftover_words", exp_q.size(), 0);
            chk("err_align", err_align, mis >= 0);
        end
    endtask

    task automatic bad_cfg(input int unsigned c, input int unsigned t);
        channel_nums = c[9:0];
        token_nums   = t[19:0];
        s_valid = 1;
        start   = 1;
        @(posedge clk); #1;
        start = 0;
        armed = 0; acc_cnt = 0; nbytes = 0; exp_q.delete();
        chk("err_cfg_set", err_cfg, 1'b1);
        chk("cfg_idle_busy", busy, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        chk("cfg_idle_s_ready", s_ready, 1'b0);
        s_valid = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 64'h0);
        chk("rst_m_tok_last", m_tok_last, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err_cfg", err_cfg, 1'b0);
        chk("rst_err_align", err_align, 1'b0);
    endtask

    initial begin
        rst = 1; start = 0; s_valid = 0; s_data = '0; s_last = 0; m_ready = 1;
        channel_nums = '0; token_nums = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check_reset_outputs();

        run_frame(16, 2, 0, -1, 0, 1);
        chk("word0_literal", first_word, 64'h0706050403020100);
        chk("word3_literal", last_word, 64'h1F1E1D1C1B1A1918);
        run_frame(16, 2, 1, -1, 0, 1);
        chk("bp_word0_literal", first_word, 64'h0706050403020100);
        run_frame(768, 8, 2, -1, 0, 0);

        bad_cfg(20, 2);
        bad_cfg(0, 2);
        bad_cfg(16, 0);

        run_frame(16, 2, 0, 30, 0, 0);
        repeat (4) begin @(posedge clk); #1; end
        chk("err_align_sticky", err_align, 1'b1);

        run_frame(16, 2, 0, -1, 13, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        armed = 0; acc_cnt = 0; nbytes = 0; final_taken = 0; done_exp = 0; prev_stall = 0;
        exp_q.delete();
        check_reset_outputs();
        run_frame(16, 2, 2, -1, 0, 0);

        run_frame(16, 2, 3, -1, 12, 0);
        run_frame(16, 2, 2, -1, 0, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
